// File: rtl/i2s_speaker_transmitter.sv
// i2s_speaker_transmitter: I2S controller-mode stereo transmitter with SCK/WS generation and a one-pair holding register
// Ports: clk_in/rst_n_in (sync, active-low), audio_data_l/r + audio_valid/audio_ready sample stream,
//        spk_sck/spk_ws/spk_sd I2S outputs, frame_start and underrun one-cycle status pulses.
// Build option: define I2S_TX_HOLD_EN to repeat the last transmitted pair on underrun instead of sending zeros.
module i2s_speaker_transmitter #(
   parameter int CLK_DIV    = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] audio_data_l,
   input  logic [DATA_WIDTH-1:0] audio_data_r,
   input  logic                  audio_valid,
   output logic                  audio_ready,
   output logic                  spk_sck,
   output logic                  spk_ws,
   output logic                  spk_sd,
   output logic                  frame_start,
   output logic                  underrun
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0]         div_q, div_d;
   logic [5:0]            bit_q, bit_d;
   logic                  sck_q, sck_d, ws_q, ws_d, sd_q, sd_d, fs_q, ur_q;
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] hold_l_q, hold_r_q, src_l, src_r;
   logic [63:0]           shift_q, shift_d;
   logic [31:0]           slot_l, slot_r;
   logic                  fall, load, accept;
   assign fall        = div_q == CW'(CLK_DIV - 1);
   assign load        = fall && bit_q == 6'd63;
   assign audio_ready = !hold_full_q && rst_n_in;
   assign accept      = audio_valid && audio_ready;
`ifdef I2S_TX_HOLD_EN
   logic [DATA_WIDTH-1:0] last_l_q, last_r_q;
   assign src_l = hold_full_q ? hold_l_q : last_l_q;
   assign src_r = hold_full_q ? hold_r_q : last_r_q;
`else
   assign src_l = hold_full_q ? hold_l_q : '0;
   assign src_r = hold_full_q ? hold_r_q : '0;
`endif
   // Samples sit MSB-aligned in their 32-bit slots; the one-bit I2S delay comes from sd lagging the shifter MSB.
   assign slot_l = 32'(src_l) << (32 - DATA_WIDTH);
   assign slot_r = 32'(src_r) << (32 - DATA_WIDTH);
   always_comb begin
      div_d       = fall ? '0 : div_q + 1'b1;
      sck_d       = fall ? 1'b0 : (div_q == CW'(CLK_DIV/2 - 1)) ? 1'b1 : sck_q;
      bit_d       = fall ? bit_q + 6'd1 : bit_q;
      ws_d        = fall ? bit_d[5] : ws_q;
      sd_d        = fall ? shift_q[63] : sd_q;
      shift_d     = load ? {slot_l, slot_r} : fall ? {shift_q[62:0], 1'b0} : shift_q;
      hold_full_d = accept ? 1'b1 : load ? 1'b0 : hold_full_q;
   end
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         div_q       <= '0;
         bit_q       <= 6'd63;
         sck_q       <= 1'b0;
         ws_q        <= 1'b0;
         sd_q        <= 1'b0;
         fs_q        <= 1'b0;
         ur_q        <= 1'b0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
`ifdef I2S_TX_HOLD_EN
         last_l_q    <= '0;
         last_r_q    <= '0;
`endif
      end else begin
         div_q       <= div_d;
         bit_q       <= bit_d;
         sck_q       <= sck_d;
         ws_q        <= ws_d;
         sd_q        <= sd_d;
         fs_q        <= load;
         ur_q        <= load && !hold_full_q;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
`ifdef I2S_TX_HOLD_EN
         if (load && hold_full_q) begin
            last_l_q <= hold_l_q;
            last_r_q <= hold_r_q;
         end
`endif
      end
   end
   always_ff @(posedge clk_in) begin
      if (accept) begin
         hold_l_q <= audio_data_l;
         hold_r_q <= audio_data_r;
      end
   end
   assign spk_sck     = sck_q;
   assign spk_ws      = ws_q;
   assign spk_sd      = sd_q;
   assign frame_start = fs_q;
   assign underrun    = ur_q;
endmodule

// File: tb/tb_i2s_speaker_transmitter.sv
// tb_i2s_speaker_transmitter: directed self-checking bench for i2s_speaker_transmitter (CLK_DIV=32, DATA_WIDTH=16)
module tb_i2s_speaker_transmitter;
`ifdef I2S_TX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif
   localparam logic [63:0] WS_EXP = 64'h0000_0000_FFFF_FFFF;
   logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0;
   logic [15:0] dl = '0, dr = '0;
   logic ready, sck, ws, sd, fs, ur;
   int cyc = 0, n_tests = 0, n_fail = 0;
   logic [15:0] pl [3] = '{16'h1111, 16'h3333, 16'h5555};
   logic [15:0] pr [3] = '{16'h2222, 16'h4444, 16'h6666};
   i2s_speaker_transmitter #(.CLK_DIV(32), .DATA_WIDTH(16)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .audio_data_l(dl), .audio_data_r(dr),
      .audio_valid(valid), .audio_ready(ready), .spk_sck(sck), .spk_ws(ws),
      .spk_sd(sd), .frame_start(fs), .underrun(ur)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] fexp(input logic [15:0] l, input logic [15:0] r);
      return {1'b0, l, 16'h0000, r, 15'h0000};
   endfunction
   task automatic check_rst_outs(input string tag);
      check({tag, "_sck"}, 64'(sck), 64'(0));
      check({tag, "_ws"}, 64'(ws), 64'(0));
      check({tag, "_sd"}, 64'(sd), 64'(0));
      check({tag, "_ready"}, 64'(ready), 64'(0));
      check({tag, "_fs"}, 64'(fs), 64'(0));
      check({tag, "_ur"}, 64'(ur), 64'(0));
   endtask
   task automatic release_chk(input logic acc, input logic [15:0] l, input logic [15:0] r, output int c0);
      int w;
      rst_n = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      check("ready_after_rel", 64'(ready), 64'(1));
      if (acc) begin
         dl = l; dr = r; valid = 1'b1;
         @(posedge clk); #1;
         valid = 1'b0;
         check("ready_after_acc", 64'(ready), 64'(0));
      end
      w = 0;
      while (!sck && w < 100) begin @(posedge clk); #1; w++; end
      check("sck_first_rise", 64'(cyc - c0), 64'(16));
   endtask
   task automatic get_frame(input int nslots, output logic [63:0] sd_b, output logic [63:0] ws_b,
                            output logic u, output int t);
      int w, s;
      logic prev;
      sd_b = '0; ws_b = '0; u = 1'b0; t = 0; w = 0; s = 0;
      while (!fs && w < 5000) begin @(posedge clk); #1; w++; end
      if (!fs) begin
         check("frame_timeout", 64'(fs), 64'(1));
         return;
      end
      u = ur; t = cyc; prev = sck; w = 0;
      while (s < nslots && w < 5000) begin
         @(posedge clk); #1; w++;
         if (sck && !prev) begin
            sd_b[63-s] = sd;
            ws_b[63-s] = ws;
            s++;
         end
         prev = sck;
      end
      check("slot_count", 64'(s), 64'(nslots));
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end
   initial begin
      logic [63:0] sdb, wsb;
      logic u;
      int t, tp, c0;
      repeat (5) @(posedge clk);
      #1;
      check_rst_outs("t1_rst");
      release_chk(1'b1, 16'hA5A5, 16'h5A5A, c0);
      get_frame(64, sdb, wsb, u, t);
      check("t2_fs_latency", 64'(t - c0), 64'(32));
      check("t2_ur", 64'(u), 64'(0));
      check("t2_sd", sdb, fexp(16'hA5A5, 16'h5A5A));
      check("t2_ws", wsb, WS_EXP);
      tp = t;
      for (int i = 0; i < 3; i++) begin
         get_frame(64, sdb, wsb, u, t);
         check("t3_period", 64'(t - tp), 64'(2048));
         check("t3_ur", 64'(u), 64'(1));
         check("t3_sd", sdb, HOLD ? fexp(16'hA5A5, 16'h5A5A) : 64'h0);
         tp = t;
      end
      fork
         begin
            int w;
            logic acc;
            for (int i = 0; i < 3; i++) begin
               dl = pl[i]; dr = pr[i]; valid = 1'b1; w = 0; acc = 1'b0;
               while (!acc && w < 5000) begin acc = ready; @(posedge clk); #1; w++; end
               check("t4_accept", 64'(acc), 64'(1));
               check("t4_ready_drop", 64'(ready), 64'(0));
            end
            valid = 1'b0;
         end
         begin
            for (int i = 0; i < 3; i++) begin
               get_frame(64, sdb, wsb, u, t);
               check("t4_period", 64'(t - tp), 64'(2048));
               check("t4_ur", 64'(u), 64'(0));
               check("t4_sd", sdb, fexp(pl[i], pr[i]));
               check("t4_ws", wsb, WS_EXP);
               tp = t;
            end
         end
      join
      repeat (15) @(posedge clk);
      #1;
      dl = 16'h7777; dr = 16'h8888; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      check("t5_ready_held", 64'(ready), 64'(0));
      check("t5_ur_pulse", 64'(ur), 64'(1));
      get_frame(64, sdb, wsb, u, t);
      check("t5_period", 64'(t - tp), 64'(2048));
      check("t5_ur", 64'(u), 64'(1));
      check("t5_sd_under", sdb, HOLD ? fexp(16'h5555, 16'h6666) : 64'h0);
      tp = t;
      get_frame(64, sdb, wsb, u, t);
      check("t5_period2", 64'(t - tp), 64'(2048));
      check("t5_ur2", 64'(u), 64'(0));
      check("t5_sd_pair", sdb, fexp(16'h7777, 16'h8888));
      dl = 16'hFFFF; dr = 16'hFFFF; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      get_frame(21, sdb, wsb, u, t);
      check("t6_partial_l", 64'(sdb[62:47]), 64'(16'hFFFF));
      check("t6_ur", 64'(u), 64'(0));
      check("t6_sck_pre", 64'(sck), 64'(1));
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_rst_outs("t6_rst");
      repeat (2) @(posedge clk);
      #1;
      release_chk(1'b0, 16'h0000, 16'h0000, c0);
      get_frame(64, sdb, wsb, u, t);
      check("t6_fs_latency", 64'(t - c0), 64'(32));
      check("t6_ur_after", 64'(u), 64'(1));
      check("t6_sd_after", sdb, 64'h0);
      check("t6_ws_after", wsb, WS_EXP);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
